// File: rtl/mem_arbiter_if.sv
// Two requester ports plus the shared 8x8 memory bus seen by mem_arbiter.
// slave = arbiter side, master = requesters and memory side.
interface mem_arbiter_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_rw, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_rw, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 8x8 memory between ports A and B:
// latch a request, run one access cycle, then pulse the winner's ack.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t        state, state_d;
  logic          last_b, last_b_d;
  logic          sel_b, sel_b_d;
  logic          lat_we, lat_we_d;
  logic [AW-1:0] lat_addr, lat_addr_d;
  logic [DW-1:0] lat_wdata, lat_wdata_d;
  logic          mem_rw, mem_rw_d;
  logic          a_ack, a_ack_d;
  logic          b_ack, b_ack_d;
  logic          busy, busy_d;
  logic [DW-1:0] a_rdata, a_rdata_d;
  logic [DW-1:0] b_rdata, b_rdata_d;
  logic          grant_b_c;

  // B wins when alone, or under contention when A was served last.
  assign grant_b_c = bus.b_req && (!bus.a_req || !last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    last_b_d    = last_b;
    sel_b_d     = sel_b;
    lat_we_d    = lat_we;
    lat_addr_d  = lat_addr;
    lat_wdata_d = lat_wdata;
    mem_rw_d    = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    busy_d      = 1'b0;
    a_rdata_d   = a_rdata;
    b_rdata_d   = b_rdata;
    case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          sel_b_d     = grant_b_c;
          last_b_d    = grant_b_c;
          lat_we_d    = grant_b_c ? bus.b_we    : bus.a_we;
          lat_addr_d  = grant_b_c ? bus.b_addr  : bus.a_addr;
          lat_wdata_d = grant_b_c ? bus.b_wdata : bus.a_wdata;
          mem_rw_d    = lat_we_d;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        busy_d  = 1'b1;
        a_ack_d = !sel_b;
        b_ack_d = sel_b;
        if (!lat_we) begin
          if (sel_b) b_rdata_d = bus.mem_rdata;
          else       a_rdata_d = bus.mem_rdata;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and latched request fields are all flops, so mem_rw is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b    <= 1'b1;
      sel_b     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      mem_rw    <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      last_b    <= last_b_d;
      sel_b     <= sel_b_d;
      lat_we    <= lat_we_d;
      lat_addr  <= lat_addr_d;
      lat_wdata <= lat_wdata_d;
      mem_rw    <= mem_rw_d;
      a_ack     <= a_ack_d;
      b_ack     <= b_ack_d;
      busy      <= busy_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
    end
  end

  assign bus.a_ack     = a_ack;
  assign bus.b_ack     = b_ack;
  assign bus.a_rdata   = a_rdata;
  assign bus.b_rdata   = b_rdata;
  assign bus.mem_rw    = mem_rw;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model, per-port request queues
// checked on every ack, plus directed timing, contention and reset scenarios.
module tb_mem_arbiter;
  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Memory instance model: combinational read, write on the clock edge.
  logic [7:0] mem [8];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;

  int n_chk  = 0;
  int n_pass = 0;

  txn_t       qa[$];
  txn_t       qb[$];
  bit         ack_log[$];
  logic [7:0] model_mem [8];
  logic [7:0] exp_ra = 8'h00;
  logic [7:0] exp_rb = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accesses are acked in service order, so applying them at ack time is exact.
  task automatic score(input bit p);
    txn_t t;
    logic [7:0] act;
    act = p ? bus.b_rdata : bus.a_rdata;
    chk(p ? "b_ack_has_request" : "a_ack_has_request",
        32'((p ? qb.size() : qa.size()) > 0), 32'd1);
    if ((p ? qb.size() : qa.size()) > 0) begin
      t = p ? qb.pop_front() : qa.pop_front();
      if (t.we) begin
        chk(p ? "b_write_keeps_rdata" : "a_write_keeps_rdata", 32'(act), 32'(p ? exp_rb : exp_ra));
        model_mem[t.addr] = t.wdata;
      end else begin
        chk(p ? "b_read_data" : "a_read_data", 32'(act), 32'(model_mem[t.addr]));
        if (p) exp_rb = model_mem[t.addr];
        else   exp_ra = model_mem[t.addr];
      end
    end
  endtask

  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      exp_ra = 8'h00;
      exp_rb = 8'h00;
    end else begin
      if (bus.a_ack || bus.b_ack) chk("ack_exclusive", 32'(bus.a_ack & bus.b_ack), 32'd0);
      if (bus.a_ack) begin ack_log.push_back(1'b0); score(1'b0); end
      if (bus.b_ack) begin ack_log.push_back(1'b1); score(1'b1); end
    end
  end

  task automatic set_req(input bit p, input logic we, input logic [2:0] addr, input logic [7:0] wd);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    if (!p) begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
      qa.push_back(t);
    end else begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
      qb.push_back(t);
    end
  endtask

  task automatic drop_req(input bit p);
    if (!p) bus.a_req = 1'b0;
    else    bus.b_req = 1'b0;
  endtask

  // Returns the number of rising edges until the port's ack is seen; a miss counts as a failure.
  task automatic wait_ack(input bit p, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if ((!p && bus.a_ack) || (p && bus.b_ack)) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk(p ? "b_ack_timeout" : "a_ack_timeout", 32'(n), 32'(max));
  endtask

  task automatic solo(input bit p, input logic we, input logic [2:0] addr, input logic [7:0] wd);
    int n;
    @(negedge clk);
    set_req(p, we, addr, wd);
    wait_ack(p, 4, n);
    chk("solo_latency", 32'(n), 32'd2);
    @(negedge clk);
    drop_req(p);
  endtask

  task automatic port_loop(input bit p, input int cnt, input int gap_max);
    int n;
    int g;
    @(negedge clk);
    set_req(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    for (int k = 0; k < cnt; k++) begin
      wait_ack(p, 6, n);
      @(negedge clk);
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (k == cnt - 1 || g > 0) drop_req(p);
      if (k < cnt - 1) begin
        repeat (g) @(negedge clk);
        set_req(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_ack"},     32'(bus.a_ack),     32'd0);
    chk({tag, "_b_ack"},     32'(bus.b_ack),     32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_mem_rw"},    32'(bus.mem_rw),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_a_rdata"},   32'(bus.a_rdata),   32'd0);
    chk({tag, "_b_rdata"},   32'(bus.b_rdata),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int n;
    int n2;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Power-on reset, then idle after release.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("por");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Fill memory, with known contents at addresses 1 and 5.
    for (int i = 0; i < 8; i++)
      solo(1'(i % 2), 1'b1, 3'(i), (i == 1) ? 8'h11 : (i == 5) ? 8'hC3 : 8'($urandom_range(0, 255)));

    // Load rdata registers, then a mid-cycle reset must clear everything without an edge.
    solo(1'b0, 1'b0, 3'd5, 8'h00);
    solo(1'b1, 1'b0, 3'd1, 8'h00);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk) rst_n = 1'b1;

    // Contention straight out of reset: A first, B three cycles later.
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd2, 8'h00);
    set_req(1'b1, 1'b0, 3'd4, 8'h00);
    wait_ack(1'b0, 4, n);
    chk("rst_contend_a_first", 32'(n), 32'd2);
    @(negedge clk) drop_req(1'b0);
    wait_ack(1'b1, 4, n2);
    chk("rst_contend_b_gap", 32'(n2), 32'd3);
    @(negedge clk) drop_req(1'b1);

    // A writes 0x5A to address 3, cycle by cycle.
    @(negedge clk);
    chk("wr_idle_mem_rw", 32'(bus.mem_rw), 32'd0);
    set_req(1'b0, 1'b1, 3'd3, 8'h5A);
    @(posedge clk); #1;
    chk("wr_access_mem_rw", 32'(bus.mem_rw), 32'd1);
    chk("wr_access_addr", 32'(bus.mem_addr), 32'd3);
    chk("wr_access_wdata", 32'(bus.mem_wdata), 32'h5A);
    chk("wr_access_busy", 32'(bus.busy), 32'd1);
    chk("wr_access_no_ack", 32'(bus.a_ack), 32'd0);
    @(posedge clk); #1;
    chk("wr_done_mem_rw", 32'(bus.mem_rw), 32'd0);
    chk("wr_done_ack", 32'(bus.a_ack), 32'd1);
    chk("wr_done_busy", 32'(bus.busy), 32'd1);
    @(negedge clk) drop_req(1'b0);
    @(posedge clk); #1;
    chk("wr_after_ack", 32'(bus.a_ack), 32'd0);
    chk("wr_after_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd3, 8'h00);
    wait_ack(1'b0, 4, n);
    chk("rd_latency", 32'(n), 32'd2);
    chk("rd_a_rdata", 32'(bus.a_rdata), 32'h5A);
    @(negedge clk) drop_req(1'b0);

    // A was served last, so contention now goes B then A.
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd5, 8'h00);
    set_req(1'b1, 1'b0, 3'd3, 8'h00);
    wait_ack(1'b1, 4, n);
    chk("contend2_b_first", 32'(n), 32'd2);
    @(negedge clk) drop_req(1'b1);
    wait_ack(1'b0, 4, n2);
    chk("contend2_a_gap", 32'(n2), 32'd3);
    @(negedge clk) drop_req(1'b0);

    // B read of address 5; its inputs change and req drops during ACCESS.
    @(negedge clk);
    set_req(1'b1, 1'b0, 3'd5, 8'h00);
    @(posedge clk); #1;
    chk("latch_busy", 32'(bus.busy), 32'd1);
    bus.b_addr = 3'd0;
    bus.b_req  = 1'b0;
    wait_ack(1'b1, 2, n);
    chk("latch_ack", 32'(n), 32'd1);
    chk("latch_b_rdata", 32'(bus.b_rdata), 32'hC3);
    repeat (3) @(posedge clk);

    // Reset during the ACCESS cycle of A's write of 0xFF to address 1.
    @(negedge clk);
    set_req(1'b0, 1'b1, 3'd1, 8'hFF);
    @(posedge clk); #1;
    chk("rstwr_mem_rw", 32'(bus.mem_rw), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rstwr");
    void'(qa.pop_back());
    drop_req(1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstwr_no_ack", 32'(bus.a_ack), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    solo(1'b0, 1'b0, 3'd1, 8'h00);
    chk("rstwr_readback", 32'(bus.a_rdata), 32'h11);

    // Both ports continuously requesting: acks must alternate.
    ack_log.delete();
    fork
      port_loop(1'b0, 4, 0);
      port_loop(1'b1, 4, 0);
    join
    repeat (4) @(posedge clk);
    chk("sustained_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 1; i < ack_log.size(); i++)
      chk("sustained_alternate", 32'(ack_log[i] != ack_log[i-1]), 32'd1);

    // Random single-port traffic.
    for (int i = 0; i < 16; i++)
      solo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)));

    // Random concurrent traffic with idle gaps.
    fork
      port_loop(1'b0, 8, 3);
      port_loop(1'b1, 8, 3);
    join
    repeat (4) @(posedge clk);
    chk("final_qa_empty", 32'(qa.size()), 32'd0);
    chk("final_qb_empty", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
